// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 sequencing controller: FETCH/DECODE/EXEC/MEM/WB with
// a data-memory ready handshake, a retired-instruction counter and halt causes.
module multicycle_control #(
    parameter int CNT_WIDTH    = 32,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic [10:0]          Opcode,
    input  logic                 Zero,
    input  logic                 MemReady,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCSrc,
    output logic                 Reg2Loc,
    output logic                 ALUSrc,
    output logic [3:0]           ALUCtrl,
    output logic [2:0]           SignOp,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 MemToReg,
    output logic                 RegWrite,
    output logic                 Halted,
    output logic [1:0]           HaltCause,
    output logic [CNT_WIDTH-1:0] RetireCount
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_ILL, C_B, C_CBZ, C_ADD, C_SUB, C_AND, C_ORR,
        C_ADDI, C_SUBI, C_LDUR, C_STUR, C_MOVZ
    } class_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t                 state_reg;
    class_t                 class_reg;
    logic [7:0]             wait_reg;
    logic [1:0]             cause_reg;
    logic [CNT_WIDTH-1:0]   retire_reg;

    class_t                 dec_class;
    class_t                 cur_class;
    logic                   pc_write_raw;
    logic                   reg_write_raw;
    logic                   mem_write_raw;

    function automatic class_t decode_op(input logic [10:0] op);
        class_t c;
        casez (op)
            11'b000101?????: c = C_B;
            11'b10110100???: c = C_CBZ;
            11'b10001011000: c = C_ADD;
            11'b11001011000: c = C_SUB;
            11'b10001010000: c = C_AND;
            11'b10101010000: c = C_ORR;
            11'b1001000100?: c = C_ADDI;
            11'b1101000100?: c = C_SUBI;
            11'b11111000010: c = C_LDUR;
            11'b11111000000: c = C_STUR;
            11'b110100101??: c = C_MOVZ;
            default:         c = C_ILL;
        endcase
        return c;
    endfunction

    function automatic logic [2:0] signop_of(input class_t c);
        logic [2:0] s;
        case (c)
            C_CBZ:          s = 3'b001;
            C_ADDI, C_SUBI: s = 3'b010;
            C_LDUR, C_STUR: s = 3'b011;
            C_MOVZ:         s = 3'b100;
            default:        s = 3'b000;
        endcase
        return s;
    endfunction

    // DECODE sees the live opcode; later states use the class latched on leaving DECODE.
    always_comb begin
        dec_class     = decode_op(Opcode);
        cur_class     = (state_reg == S_DECODE) ? dec_class : class_reg;
        IRWrite       = 1'b0;
        pc_write_raw  = 1'b0;
        PCSrc         = 1'b0;
        Reg2Loc       = 1'b0;
        ALUSrc        = 1'b0;
        ALUCtrl       = 4'b0000;
        SignOp        = 3'b000;
        MemRead       = 1'b0;
        mem_write_raw = 1'b0;
        MemToReg      = 1'b0;
        reg_write_raw = 1'b0;

        if (state_reg inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            SignOp  = signop_of(cur_class);
            Reg2Loc = (cur_class == C_STUR) || (cur_class == C_CBZ);
        end

        case (state_reg)
            S_FETCH: IRWrite = 1'b1;
            S_EXEC: begin
                case (class_reg)
                    C_ADD:  ALUCtrl = 4'b0010;
                    C_SUB:  ALUCtrl = 4'b0110;
                    C_AND:  ALUCtrl = 4'b0000;
                    C_ORR:  ALUCtrl = 4'b0001;
                    C_ADDI: begin ALUSrc = 1'b1; ALUCtrl = 4'b0010; end
                    C_SUBI: begin ALUSrc = 1'b1; ALUCtrl = 4'b0110; end
                    C_MOVZ: begin ALUSrc = 1'b1; ALUCtrl = 4'b0111; end
                    C_LDUR, C_STUR: begin ALUSrc = 1'b1; ALUCtrl = 4'b0010; end
                    C_B:    begin pc_write_raw = 1'b1; PCSrc = 1'b1; end
                    C_CBZ:  begin ALUCtrl = 4'b0111; pc_write_raw = 1'b1; PCSrc = Zero; end
                    default: ;
                endcase
            end
            S_MEM: begin
                MemRead       = (class_reg == C_LDUR);
                mem_write_raw = (class_reg == C_STUR);
                pc_write_raw  = (class_reg == C_STUR) && MemReady;
            end
            S_WB: begin
                reg_write_raw = 1'b1;
                MemToReg      = (class_reg == C_LDUR);
                pc_write_raw  = 1'b1;
            end
            default: ;
        endcase
    end

    // An edge that carries Reset must not commit any architectural write.
    assign PCWrite     = pc_write_raw & ~Reset;
    assign RegWrite    = reg_write_raw & ~Reset;
    assign MemWrite    = mem_write_raw & ~Reset;
    assign Halted      = (state_reg == S_HALT);
    assign HaltCause   = cause_reg;
    assign RetireCount = retire_reg;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_reg  <= S_FETCH;
            class_reg  <= C_ILL;
            wait_reg   <= 8'd0;
            cause_reg  <= 2'b00;
            retire_reg <= '0;
        end else begin
            case (state_reg)
                S_FETCH: state_reg <= S_DECODE;
                S_DECODE: begin
                    class_reg <= dec_class;
                    if (dec_class == C_ILL) begin
                        state_reg <= S_HALT;
                        cause_reg <= 2'b01;
                    end else begin
                        state_reg <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (class_reg)
                        C_B, C_CBZ: begin
                            state_reg  <= S_FETCH;
                            retire_reg <= retire_reg + CNT_WIDTH'(1);
                        end
                        C_LDUR, C_STUR: state_reg <= S_MEM;
                        default:        state_reg <= S_WB;
                    endcase
                end
                S_MEM: begin
                    if (MemReady) begin
                        wait_reg <= 8'd0;
                        if (class_reg == C_STUR) begin
                            state_reg  <= S_FETCH;
                            retire_reg <= retire_reg + CNT_WIDTH'(1);
                        end else begin
                            state_reg <= S_WB;
                        end
                    end else if (wait_reg == WAIT_LAST) begin
                        // This cycle is the MEM_WAIT_MAX-th consecutive miss.
                        wait_reg  <= 8'd0;
                        state_reg <= S_HALT;
                        cause_reg <= 2'b10;
                    end else begin
                        wait_reg <= wait_reg + 8'd1;
                    end
                end
                S_WB: begin
                    state_reg  <= S_FETCH;
                    retire_reg <= retire_reg + CNT_WIDTH'(1);
                end
                S_HALT:  state_reg <= S_HALT;
                default: state_reg <= S_HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a cycle-indexed instruction model is
// compared against every output on each falling edge, plus literal spot checks.
module tb_multicycle_control;

    localparam int CW   = 4;
    localparam int MAXW = 15;

    localparam int K_ILL = 0, K_B = 1, K_CBZ = 2, K_ADD = 3, K_SUB = 4, K_AND = 5,
                   K_ORR = 6, K_ADDI = 7, K_SUBI = 8, K_LDUR = 9, K_STUR = 10, K_MOVZ = 11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_MOVZ = 11'b11010010100;
    localparam logic [10:0] OP_CBZ  = 11'b10110100000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_B    = 11'b00010100000;

    logic          CLK = 1'b0;
    logic          Reset;
    logic [10:0]   Opcode;
    logic          Zero;
    logic          MemReady;
    logic          IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc;
    logic [3:0]    ALUCtrl;
    logic [2:0]    SignOp;
    logic          MemRead, MemWrite, MemToReg, RegWrite, Halted;
    logic [1:0]    HaltCause;
    logic [CW-1:0] RetireCount;

    multicycle_control #(.CNT_WIDTH(CW), .MEM_WAIT_MAX(MAXW)) dut (
        .CLK(CLK), .Reset(Reset), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .Reg2Loc(Reg2Loc),
        .ALUSrc(ALUSrc), .ALUCtrl(ALUCtrl), .SignOp(SignOp), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .Halted(Halted), .HaltCause(HaltCause), .RetireCount(RetireCount)
    );

    always #5 CLK = ~CLK;

    // Bit layout: [22]IRW [21]PCW [20]PCSrc [19]R2L [18]ALUSrc [17:14]ALU
    // [13:11]SignOp [10]MRd [9]MWr [8]M2R [7]RW [6]Halted [5:4]Cause [3:0]Count
    logic [22:0] dut_vec;
    assign dut_vec = {IRWrite, PCWrite, PCSrc, Reg2Loc, ALUSrc, ALUCtrl, SignOp,
                      MemRead, MemWrite, MemToReg, RegWrite, Halted, HaltCause, RetireCount};

    typedef struct packed {
        logic [7:0] k;        // cycle index within current instruction
        logic [3:0] cls;
        logic       memdone;
        logic [7:0] waits;
        logic       halt;
        logic [1:0] cause;
        logic [3:0] rc;
    } mstate_t;

    mstate_t m;
    int      checks = 0;
    int      errors = 0;
    bit      chk_en = 0;
    logic [22:0] snap [64];

    function automatic int bdecode(input logic [10:0] op);
        casez (op)
            11'b000101?????: return K_B;
            11'b10110100???: return K_CBZ;
            11'b10001011000: return K_ADD;
            11'b11001011000: return K_SUB;
            11'b10001010000: return K_AND;
            11'b10101010000: return K_ORR;
            11'b1001000100?: return K_ADDI;
            11'b1101000100?: return K_SUBI;
            11'b11111000010: return K_LDUR;
            11'b11111000000: return K_STUR;
            11'b110100101??: return K_MOVZ;
            default:         return K_ILL;
        endcase
    endfunction

    function automatic logic [2:0] sop_of(input int c);
        if (c == K_CBZ) return 3'd1;
        if (c == K_ADDI || c == K_SUBI) return 3'd2;
        if (c == K_LDUR || c == K_STUR) return 3'd3;
        if (c == K_MOVZ) return 3'd4;
        return 3'd0;
    endfunction

    function automatic mstate_t model_next(input mstate_t s, input logic rst,
                                           input logic [10:0] op, input logic mr);
        mstate_t n;
        logic fin;
        int c;
        n = s;
        fin = 1'b0;
        c = int'(s.cls);
        if (rst) return '0;
        if (s.halt) return s;
        if (s.k == 8'd1) begin
            n.cls = 4'(bdecode(op));
            if (bdecode(op) == K_ILL) begin
                n.halt = 1'b1;
                n.cause = 2'd1;
            end
        end else if (s.k == 8'd2) begin
            fin = (c == K_B || c == K_CBZ);
        end else if (s.k >= 8'd3) begin
            if ((c == K_LDUR || c == K_STUR) && !s.memdone) begin
                if (mr) begin
                    n.memdone = 1'b1;
                    fin = (c == K_STUR);
                end else begin
                    n.waits = s.waits + 8'd1;
                    if (n.waits == 8'(MAXW)) begin
                        n.halt = 1'b1;
                        n.cause = 2'd2;
                    end
                end
            end else begin
                fin = 1'b1;
            end
        end
        if (fin) begin
            n.rc = s.rc + 4'd1;
            n.k = 8'd0;
            n.waits = 8'd0;
            n.memdone = 1'b0;
        end else if (!n.halt) begin
            n.k = s.k + 8'd1;
        end
        return n;
    endfunction

    function automatic logic [22:0] exp_vec(input mstate_t s, input logic rst,
                                            input logic [10:0] op, input logic z, input logic mr);
        logic irw, pcw, pcsrc, r2l, alusrc, mrd, mwr, m2r, rw, hl;
        logic [3:0] alu;
        logic [2:0] sop;
        int c;
        {irw, pcw, pcsrc, r2l, alusrc, mrd, mwr, m2r, rw, hl} = '0;
        alu = 4'd0;
        sop = 3'd0;
        if (s.halt) begin
            hl = 1'b1;
        end else if (s.k == 8'd0) begin
            irw = 1'b1;
        end else begin
            c = (s.k == 8'd1) ? bdecode(op) : int'(s.cls);
            sop = sop_of(c);
            r2l = (c == K_STUR || c == K_CBZ);
            if (s.k == 8'd2) begin
                case (c)
                    K_ADD:  alu = 4'd2;
                    K_SUB:  alu = 4'd6;
                    K_AND:  alu = 4'd0;
                    K_ORR:  alu = 4'd1;
                    K_ADDI: begin alusrc = 1'b1; alu = 4'd2; end
                    K_SUBI: begin alusrc = 1'b1; alu = 4'd6; end
                    K_MOVZ: begin alusrc = 1'b1; alu = 4'd7; end
                    K_LDUR, K_STUR: begin alusrc = 1'b1; alu = 4'd2; end
                    K_B:    begin pcw = 1'b1; pcsrc = 1'b1; end
                    K_CBZ:  begin alu = 4'd7; pcw = 1'b1; pcsrc = z; end
                    default: ;
                endcase
            end else if (s.k >= 8'd3) begin
                if ((c == K_LDUR || c == K_STUR) && !s.memdone) begin
                    mrd = (c == K_LDUR);
                    mwr = (c == K_STUR);
                    pcw = (c == K_STUR) && mr;
                end else begin
                    rw = 1'b1;
                    m2r = (c == K_LDUR);
                    pcw = 1'b1;
                end
            end
        end
        if (rst) begin
            pcw = 1'b0;
            rw = 1'b0;
            mwr = 1'b0;
        end
        return {irw, pcw, pcsrc, r2l, alusrc, alu, sop, mrd, mwr, m2r, rw, hl, s.cause, s.rc};
    endfunction

    always @(posedge CLK) m <= model_next(m, Reset, Opcode, MemReady);

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
    endtask

    // Runs one instruction from FETCH; MemReady rises in the (waits+1)-th MEM cycle.
    task automatic run_instr(input logic [10:0] op, input logic z, input int waits,
                             input int exp_lat, input string name);
        int i;
        bit done;
        i = 0;
        done = 1'b0;
        Opcode = op;
        Zero = z;
        while (!done && i < 40) begin
            MemReady = (i < 2) || (i == 3 + waits);
            #1;
            snap[i] = dut_vec;
            step();
            i++;
            if (IRWrite || Halted) done = 1'b1;
        end
        $display("instr %s op=%b zero=%0d waits=%0d cycles=%0d count=%0d halted=%0d",
                 name, op, z, waits, i, RetireCount, Halted);
        check({name, "_latency"}, i, exp_lat);
    endtask

    function automatic int count_bit(input int pos, input int n);
        int s;
        s = 0;
        for (int j = 0; j < n; j++) s += int'(snap[j][pos]);
        return s;
    endfunction

    typedef struct packed {
        logic [10:0] op;
        logic        z;
        logic [7:0]  waits;
        logic [7:0]  lat;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{11'b11001011000, 1'b0, 8'd0, 8'd4};  // SUB
        tbl[1] = '{11'b10001010000, 1'b0, 8'd0, 8'd4};  // AND
        tbl[2] = '{11'b10101010000, 1'b0, 8'd0, 8'd4};  // ORR
        tbl[3] = '{11'b10010001001, 1'b0, 8'd0, 8'd4};  // ADDI
        tbl[4] = '{11'b11010001000, 1'b0, 8'd0, 8'd4};  // SUBI
        tbl[5] = '{OP_LDUR,         1'b0, 8'd0, 8'd5};
        tbl[6] = '{OP_STUR,         1'b0, 8'd0, 8'd4};
        tbl[7] = '{OP_STUR,         1'b0, 8'd2, 8'd6};
        tbl[8] = '{11'b00010111111, 1'b0, 8'd0, 8'd3};  // B
        tbl[9] = '{11'b10110100111, 1'b1, 8'd0, 8'd3};  // CBZ

        Reset = 1'b1;
        Opcode = 11'd0;
        Zero = 1'b0;
        MemReady = 1'b0;

        fork
            forever begin
                @(negedge CLK);
                if (chk_en) begin
                    logic [22:0] e;
                    e = exp_vec(m, Reset, Opcode, Zero, MemReady);
                    checks++;
                    if (dut_vec !== e) begin
                        errors++;
                        $display("FAIL cycle_outputs t=%0t actual %b required %b", $time, dut_vec, e);
                    end
                end
            end
        join_none

        step();
        chk_en = 1'b1;
        Reset = 1'b0;
        #1;
        check("reset_count", int'(RetireCount), 0);
        check("reset_halted", int'(Halted), 0);
        check("reset_cause", int'(HaltCause), 0);
        check("reset_irwrite", int'(IRWrite), 1);

        run_instr(OP_ADD, 1'b0, 0, 4, "add");
        check("add_wb_regwrite", int'(snap[3][7]), 1);
        run_instr(OP_MOVZ, 1'b0, 0, 4, "movz");
        check("movz_alusrc", int'(snap[2][18]), 1);
        check("movz_aluctrl", int'(snap[2][17:14]), 7);
        check("movz_signop", int'(snap[2][13:11]), 4);
        check("movz_wb_regwrite", int'(snap[3][7]), 1);
        check("count_after_add_movz", int'(RetireCount), 2);

        run_instr(OP_CBZ, 1'b1, 0, 3, "cbz_taken");
        check("cbz1_pcwrite", int'(snap[2][21]), 1);
        check("cbz1_pcsrc", int'(snap[2][20]), 1);
        check("cbz1_signop", int'(snap[2][13:11]), 1);
        run_instr(OP_CBZ, 1'b0, 0, 3, "cbz_not_taken");
        check("cbz0_pcsrc", int'(snap[2][20]), 0);
        check("cbz0_pcwrite", int'(snap[2][21]), 1);

        run_instr(OP_LDUR, 1'b0, 3, 8, "ldur_wait3");
        check("ldur_memread_cycles", count_bit(10, 8), 4);
        check("ldur_signop_exec", int'(snap[2][13:11]), 3);
        check("ldur_signop_mem", int'(snap[5][13:11]), 3);
        check("ldur_wb_memtoreg", int'(snap[7][8]), 1);
        check("ldur_wb_regwrite", int'(snap[7][7]), 1);
        check("count_after_ldur", int'(RetireCount), 5);

        for (int t = 0; t < 10; t++)
            run_instr(tbl[t].op, tbl[t].z, int'(tbl[t].waits), int'(tbl[t].lat),
                      $sformatf("tbl%0d", t));
        check("count_after_table", int'(RetireCount), 15);

        run_instr(OP_STUR, 1'b0, 100, 18, "stur_stuck");
        check("stuck_memwrite_cycles", count_bit(9, 18), 15);
        check("stuck_halted", int'(Halted), 1);
        check("stuck_cause", int'(HaltCause), 2);
        check("stuck_memwrite_off", int'(MemWrite), 0);
        check("stuck_count", int'(RetireCount), 15);
        MemReady = 1'b1;
        repeat (3) step();
        check("halt_frozen_halted", int'(Halted), 1);
        check("halt_frozen_count", int'(RetireCount), 15);

        do_reset();
        check("post_halt_reset_count", int'(RetireCount), 0);
        run_instr(11'b00000000000, 1'b0, 0, 2, "illegal_zero");
        check("illegal_cause", int'(HaltCause), 1);
        check("illegal_halted", int'(Halted), 1);
        do_reset();
        check("pulse_irwrite", int'(IRWrite), 1);
        check("pulse_halted", int'(Halted), 0);
        check("pulse_count", int'(RetireCount), 0);
        run_instr(11'b11111000001, 1'b0, 0, 2, "illegal_near_ldur");
        check("near_ldur_cause", int'(HaltCause), 1);
        do_reset();

        for (int n = 0; n < 16; n++) begin
            run_instr(OP_B, 1'b0, 0, 3, "b_wrap");
            if (n == 14) check("count_before_wrap", int'(RetireCount), 15);
        end
        check("count_wrapped", int'(RetireCount), 0);

        Opcode = OP_LDUR;
        Zero = 1'b0;
        MemReady = 1'b0;
        repeat (4) step();
        check("abort_in_mem_memread", int'(MemRead), 1);
        Reset = 1'b1;
        #1;
        check("abort_pcwrite", int'(PCWrite), 0);
        check("abort_regwrite", int'(RegWrite), 0);
        step();
        Reset = 1'b0;
        #1;
        $display("instr ldur_abort op=%b count=%0d irwrite=%0d", OP_LDUR, RetireCount, IRWrite);
        check("abort_fetch", int'(IRWrite), 1);
        check("abort_count", int'(RetireCount), 0);
        run_instr(OP_ADD, 1'b0, 0, 4, "add_after_abort");
        check("count_after_abort", int'(RetireCount), 1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multi-cycle sequencing controller for the LEGv8 datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB. In every state it drives the datapath enables, the ALU control and the 3-bit immediate-format select (SignOp) consumed by the sign extender. It also waits on a data-memory ready handshake, counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
CNT_WIDTH, 32, width of the retired-instruction counter.
MEM_WAIT_MAX, 15, maximum consecutive MEM-state cycles with MemReady=0 before a timeout halt (range 1..255).

Ports:
CLK  input  1  clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
Opcode  input  11  instruction bits [31:21] from the instruction register; valid from DECODE onward.
Zero  input  1  ALU zero flag, sampled in EXEC for CBZ.
MemReady  input  1  data memory has completed the access this cycle.
IRWrite  output  1  load the instruction register.
PCWrite  output  1  update the PC this cycle.
PCSrc  output  1  PC source: 0 = PC+4, 1 = PC + branch offset.
Reg2Loc  output  1  second register read port selects Rt.
ALUSrc  output  1  ALU B operand = extended immediate.
ALUCtrl  output  4  0000 AND, 0001 ORR, 0010 ADD, 0110 SUB, 0111 pass-B.
SignOp  output  3  000 B, 001 CBZ, 010 I, 011 D, 100 IW.
MemRead  output  1  data memory read.
MemWrite  output  1  data memory write.
MemToReg  output  1  write-back data comes from memory.
RegWrite  output  1  register file write.
Halted  output  1  controller is in HALT.
HaltCause  output  2  00 none, 01 illegal opcode, 10 memory timeout.
RetireCount  output  CNT_WIDTH  number of retired instructions.

Behaviour:
- Reset (synchronous, priority over everything): state=FETCH; class register and wait counter cleared; RetireCount=0; HaltCause=00; Halted=0.
- Outputs decode combinationally from state plus the latched class. Any output not listed for a state is 0; SignOp is 000 in FETCH.
- Opcode decode, latched at the DECODE→EXEC edge (x = don't care):
  - B 000101xxxxx
  - CBZ 10110100xxx
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000
  - ADDI 1001000100x, SUBI 1101000100x
  - LDUR 11111000010, STUR 11111000000
  - MOVZ 110100101xx
  - anything else is illegal.
- FETCH: IRWrite=1. Next state DECODE.
- DECODE: SignOp is driven for the decoded class. Next state EXEC; an illegal opcode goes to HALT and sets HaltCause=01.
- From DECODE to instruction end, SignOp and Reg2Loc are held per class:
  - SignOp: B 000, CBZ 001, ADDI/SUBI 010, LDUR/STUR 011, MOVZ 100, R-type 000.
  - Reg2Loc=1 for STUR and CBZ.
- EXEC:
  - R-type: ALUCtrl per op. Next state WB.
  - ADDI/SUBI: ALUSrc=1, ALUCtrl ADD or SUB. Next state WB.
  - MOVZ: ALUSrc=1, ALUCtrl 0111. Next state WB.
  - LDUR/STUR: ALUSrc=1, ALUCtrl ADD. Next state MEM.
  - B: PCWrite=1, PCSrc=1. Retire. Next state FETCH.
  - CBZ: ALUCtrl 0111, PCWrite=1, PCSrc=Zero. Retire. Next state FETCH.
- MEM:
  - MemRead (LDUR) or MemWrite (STUR) is held every cycle until MemReady=1.
  - On MemReady=1, LDUR goes to WB. STUR asserts PCWrite=1 with PCSrc=0 in that same cycle, retires and goes to FETCH.
  - The wait counter increments each cycle with MemReady=0 and clears on leaving MEM.
  - If the counter reaches MEM_WAIT_MAX while MemReady=0, go to HALT with HaltCause=10.
  - MemReady sampled in any other state is ignored.
- WB: RegWrite=1, MemToReg=1 for LDUR only, PCWrite=1, PCSrc=0. Retire. Next state FETCH.
- Retire: RetireCount increments by 1 on the edge leaving the final state; it wraps from all-ones to 0 silently.
- HALT: Halted=1 and every enable is 0. Only Reset leaves HALT. HaltCause and RetireCount are frozen.
- Latency in cycles:
  - B, CBZ: 3
  - STUR: 4 + wait cycles
  - R-type, ADDI, SUBI, MOVZ: 4
  - LDUR: 5 + wait cycles
- Reset asserted mid-instruction (including during a MEM wait) aborts it: no retire and no PCWrite on that edge.

Test Plan:
- ADD (10001011000) then MOVZ (11010010100): state sequence FETCH, DECODE, EXEC, WB each. MOVZ EXEC shows ALUSrc=1, ALUCtrl=0111, SignOp=100. RegWrite=1 in both WB cycles. RetireCount=2 after 8 cycles.
- CBZ with Zero=1: PCWrite=1, PCSrc=1, SignOp=001 in cycle 3. Repeat with Zero=0: PCSrc=0. Each retires in 3 cycles.
- LDUR with MemReady low for 3 MEM cycles: MemRead=1 for 4 cycles, SignOp=011 throughout. WB follows with MemToReg=1 and RegWrite=1. Total 8 cycles.
- STUR with MemReady stuck at 0 and MEM_WAIT_MAX=15: HALT entered after 15 wait cycles, Halted=1, HaltCause=10, MemWrite drops to 0, RetireCount unchanged.
- Opcode 00000000000: HALT after DECODE with HaltCause=01. A 1-cycle Reset pulse returns to FETCH with RetireCount=0.
- CNT_WIDTH=4: 16 B instructions retired → RetireCount wraps to 0. Reset asserted in an LDUR MEM cycle → FETCH next cycle, no RegWrite, no retire.
